// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer
// Takes a raster-ordered pixel stream on a valid/ready handshake and writes
// each pixel into the frame BRAM at row*H_ACTIVE+col. The address is built
// by counting, not by multiplying. The block locks onto start-of-frame,
// restarts when an SOF arrives mid-frame, and pulses frame_done once the last
// pixel of a frame has been written.
//
// state | meaning
// IDLE  | waiting for SOF; beats without SOF are dropped
// WRITE | frame in progress; every beat is written and the counters advance
// DONE  | one cycle; the final write and frame_done appear, and input is stalled
module frame_buffer_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_sof_i,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_din_o,
    output logic              bram_we_o,
    output logic              frame_done_o,
    output logic              resync_o,
    output logic              busy_o
);

    localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                we_q, we_d;
    logic                done_q, done_d;
    logic                resync_q, resync_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic                accept;
    logic [COL_W-1:0]    base_col;
    logic [ROW_W-1:0]    base_row;
    logic [ADDR_W-1:0]   base_addr;
    logic                base_last;

    assign accept = s_valid_i && ready_q;

    // Write position for this beat: an SOF restarts at the origin, otherwise
    // use the current counters.
    always_comb begin
        base_col  = col_q;
        base_row  = row_q;
        base_addr = addr_q;
        if (s_sof_i) begin
            base_col  = '0;
            base_row  = '0;
            base_addr = '0;
        end
        base_last = (base_col == COL_W'(H_ACTIVE - 1)) &&
                    (base_row == ROW_W'(V_ACTIVE - 1));
    end

    // Next-state, counter advance and registered-output decode.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        din_d     = din_q;
        we_d      = 1'b0;
        done_d    = 1'b0;
        resync_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_WRITE: begin
                // In IDLE, only an SOF beat opens a frame.
                if (accept && (s_sof_i || state_q == ST_WRITE)) begin
                    we_d      = 1'b1;
                    wr_addr_d = base_addr;
                    din_d     = s_data_i;
                    resync_d  = s_sof_i && (state_q == ST_WRITE);
                    if (base_last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        col_d   = '0;
                        row_d   = '0;
                        addr_d  = '0;
                    end else begin
                        state_d = ST_WRITE;
                        addr_d  = base_addr + ADDR_W'(1);
                        if (base_col == COL_W'(H_ACTIVE - 1)) begin
                            col_d = '0;
                            row_d = base_row + ROW_W'(1);
                        end else begin
                            col_d = base_col + COL_W'(1);
                            row_d = base_row;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d != ST_DONE);
        busy_d  = (state_d == ST_WRITE);
    end

    // State, counters and outputs; reset clears everything but the BRAM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            resync_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            din_q     <= din_d;
            we_q      <= we_d;
            done_q    <= done_d;
            resync_q  <= resync_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign s_ready_o    = ready_q;
    assign bram_addr_o  = wr_addr_q;
    assign bram_din_o   = din_q;
    assign bram_we_o    = we_q;
    assign frame_done_o = done_q;
    assign resync_o     = resync_q;
    assign busy_o       = busy_q;

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
Write-side counterpart of the VGA scan-out path. It accepts a raster-ordered 8-bit grayscale pixel stream (for example Sobel output) over a valid/ready handshake and writes each pixel into the 640x480 frame BRAM. Each pixel goes to address row*H_ACTIVE+col, the same addressing the display reader uses. It aligns to start-of-frame markers, resynchronises on a misplaced SOF, and reports frame completion.

Parameters:
H_ACTIVE, 640, pixels per line
V_ACTIVE, 480, lines per frame
DATA_W, 8, pixel width in bits
ADDR_W, 19, BRAM address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

Ports:
clk  in  1  system clock, the same clock that drives the BRAM port
rst  in  1  synchronous, active-high reset
s_valid  in  1  input pixel valid
s_ready  out  1  block can accept a pixel this cycle
s_data  in  DATA_W  pixel value
s_sof  in  1  marks the first pixel of a frame; qualified by s_valid
bram_addr  out  ADDR_W  BRAM write address
bram_din  out  DATA_W  BRAM write data
bram_we  out  1  BRAM write enable
frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
resync  out  1  one-cycle pulse when a frame is aborted by an early SOF
busy  out  1  high while a frame is in progress (state WRITE)

Behaviour:
- Interface: clock is clk; reset is synchronous and active-high (rst), sampled on the posedge of clk.
- A beat is accepted when s_valid && s_ready at a posedge.
- Reset values: s_ready=0, bram_we=0, bram_addr=0, bram_din=0, frame_done=0, resync=0, busy=0. State is IDLE; col=0, row=0, addr=0.
- All outputs are registered. Write latency: a beat accepted at edge N produces bram_we=1 with bram_addr and bram_din valid in the cycle after edge N. bram_we is high for exactly one cycle per accepted beat.
- Address generation is incremental with no multiplier:
  - addr increments by 1 per accepted beat.
  - col wraps at H_ACTIVE-1 to 0, and row then increments.
- States:
  - IDLE: s_ready=1.
    - Beat with s_sof=1: write it at addr 0; set col=1, addr=1 (row=0) → WRITE.
    - Beat with s_sof=0: discarded (no write) and stays IDLE; this drains stale pixels.
  - WRITE: s_ready=1, busy=1.
    - Each beat without s_sof is written at the current addr, then the counters advance.
    - The beat at col=H_ACTIVE-1, row=V_ACTIVE-1 (addr=H_ACTIVE*V_ACTIVE-1) is written, then the state goes to DONE.
    - Beat with s_sof=1 (mid-frame): pulse resync; write that pixel at addr 0; set col=1, row=0, addr=1; stay in WRITE.
  - DONE: exactly one cycle. s_ready=0, busy=0; frame_done=1 in this cycle, then IDLE. The final write and the frame_done pulse are in the same cycle.
- s_valid low in WRITE: no write, counters hold, no timeout.
- SOF on the final pixel of a frame is a resync: the pixel is written to addr 0, no frame_done, and the state stays in WRITE.
- s_sof without s_valid is ignored.
- rst mid-frame: the next cycle has the reset values. The partial frame is abandoned and no frame_done is issued. BRAM contents are untouched.
- No back-pressure from the BRAM; a write is assumed to complete in one cycle.

Test Plan:
1. Use H_ACTIVE=4, V_ACTIVE=3. Stream 12 beats 0x00..0x0B, with s_sof on the first and s_valid held high → writes to addr 0..11 with din equal to addr, one cycle after each accept. frame_done pulses once, together with the addr-11 write. s_ready=0 for that one cycle. busy falls.
2. Use H_ACTIVE=4, V_ACTIVE=3. Send 3 beats without SOF, then a frame with SOF → the first 3 beats produce no bram_we; the frame is written at addr 0..11.
3. Use H_ACTIVE=4, V_ACTIVE=3. After 5 beats, send a beat 0xAA with s_sof=1 → resync pulses; 0xAA is written to addr 0; the next beat goes to addr 1. frame_done arrives only after 11 further beats.
4. Toggle s_valid 1/0 randomly through a full frame → the address sequence is contiguous 0..11 with no duplicates or skips, and bram_we count=12.
5. Assert rst for one cycle after 7 beats → all outputs are 0 the next cycle; a new SOF frame is written starting at addr 0, with no frame_done for the aborted frame.
6. Use default parameters on a full 640x480 frame → the last write is at addr 307199 with frame_done; row wraps correctly at each multiple of 640, checked at addr 639→640.
